// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns engine.
// One shared column datapath walks the four columns of a held state.
module inv_mix_columns_seq #(
  parameter bit INV_IN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] data_q;
  logic [127:0] data_d;

  logic [31:0]  col_raw;
  logic [31:0]  col_a;
  logic [31:0]  col_r;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    logic [7:0] b8;
    b8 = xt(xt(xt(b)));
    m09 = b8 ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    logic [7:0] b2;
    b2 = xt(b);
    m0b = xt(xt(b2)) ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    logic [7:0] b4;
    b4 = xt(xt(b));
    m0d = xt(b4) ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    logic [7:0] b2;
    logic [7:0] b4;
    b2 = xt(b);
    b4 = xt(b2);
    m0e = xt(b4) ^ b4 ^ b2;
  endfunction

  // Select the active column, optionally undo the forward complement
  always_comb begin
    col_raw = 32'h0;
    unique case (col_q)
      2'd0: col_raw = data_q[127:96];
      2'd1: col_raw = data_q[95:64];
      2'd2: col_raw = data_q[63:32];
      2'd3: col_raw = data_q[31:0];
      default: col_raw = 32'h0;
    endcase
    col_a = INV_IN ? ~col_raw : col_raw;
  end

  // Shared InvMixColumns column datapath
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = col_a[31:24];
    a1 = col_a[23:16];
    a2 = col_a[15:8];
    a3 = col_a[7:0];
    col_r[31:24] = m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3);
    col_r[23:16] = m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3);
    col_r[15:8]  = m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3);
    col_r[7:0]   = m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3);
  end

  // Write the column result back into its slot
  always_comb begin
    data_d = data_q;
    unique case (col_q)
      2'd0: data_d[127:96] = col_r;
      2'd1: data_d[95:64]  = col_r;
      2'd2: data_d[63:32]  = col_r;
      2'd3: data_d[31:0]   = col_r;
      default: data_d = data_q;
    endcase
  end

  // Sequencer: accept, walk four columns, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            col_q   <= 2'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          data_q <= data_d;
          col_q  <= col_q + 2'd1;
          if (col_q == 2'd3) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_q  <= in_data;
              col_q   <= 2'd0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and soak bench for inv_mix_columns_seq.
// Expected values are hand vectors plus an independent GF model.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;

  logic         in_valid0, in_ready0;
  logic         out_valid0, out_ready0;
  logic [127:0] out_data0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.INV_IN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  inv_mix_columns_seq #(.INV_IN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0)
  );

  localparam logic [127:0] V1_IN  = {4{32'h71B25E43}};
  localparam logic [127:0] V1_OUT = {4{32'hDB135345}};
  localparam logic [127:0] V2_IN  =
    128'h6023A762_2A2A2829_FEFEFEFE_39393939;
  localparam logic [127:0] V2_OUT =
    128'hF20A225C_D4D4D4D5_01010101_C6C6C6C6;
  localparam logic [127:0] V3_IN  = {4{32'h8E4DA1BC}};

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] k [4];
    logic [31:0] r;
    k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    for (int row = 0; row < 4; row++) begin
      logic [7:0] s;
      s = 8'h0;
      for (int j = 0; j < 4; j++)
        s = s ^ gmul(k[(j - row + 4) % 4], a[j]);
      r[31-8*row -: 8] = s;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      r[127-32*c -: 32] = ref_col(~s[127-32*c -: 32]);
    return r;
  endfunction

  // Wait for out_valid, returning posedges since the accept edge
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [127:0] q [$];
  int sent, rcvd, cyc, lat;
  logic         hold_p;
  logic [127:0] hold_d;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_data", 160'(out_data), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("model_sanity", 160'(ref_state(V2_IN)), 160'(V2_OUT));

    // FIPS column, latency and first accept after release
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = V1_IN;
    @(negedge clk);
    in_valid = 1'b0;
    chk("v1_busy_ready", 160'(in_ready), 160'(0));
    wait_out(lat);
    chk("v1_latency", 160'(lat), 160'(4));
    chk("v1_data", 160'(out_data), 160'(V1_OUT));

    // Backpressure hold in DONE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {31'h0, out_valid, in_ready, out_data},
          {31'h0, 1'b1, 1'b0, V1_OUT});
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = V2_IN;
    #1;
    chk("bp_pass_ready", 160'(in_ready), 160'(1));
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_busy", 160'(out_valid), 160'(0));
    wait_out(lat);
    chk("v2_latency", 160'(lat), 160'(4));
    chk("v2_data", 160'(out_data), 160'(V2_OUT));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_idle", {158'h0, out_valid, in_ready}, 160'b01);

    // Uncomplemented build
    in_valid0 = 1'b1;
    in_data = V3_IN;
    @(negedge clk);
    in_valid0 = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("inv0_latency", 160'(lat), 160'(4));
    chk("inv0_data", 160'(out_data0), 160'(V1_OUT));
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;

    // Reset two cycles into BUSY
    in_valid = 1'b1; in_data = V2_IN;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 160'(out_valid), 160'(0));
    chk("mid_rst_data", 160'(out_data), 160'(0));
    chk("mid_rst_ready", 160'(in_ready), 160'(1));
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = V1_IN;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("post_rst_lat", 160'(lat), 160'(4));
    chk("post_rst_data", 160'(out_data), 160'(V1_OUT));
    out_ready = 1'b1;
    @(negedge clk);

    // Random soak with scoreboard
    sent = 0; rcvd = 0; cyc = 0; hold_p = 1'b0; hold_d = '0;
    while (rcvd < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (hold_p)
        chk("soak_hold", {31'h0, out_valid, out_data},
            {31'h0, 1'b1, hold_d});
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("soak_extra", 160'(1), 160'(0));
        end else begin
          chk("soak_data", 160'(out_data), 160'(q.pop_front()));
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_state(in_data));
        sent++;
      end
      hold_p = out_valid && !out_ready;
      hold_d = out_data;
    end
    chk("soak_count", 160'(rcvd), 160'(1000));
    chk("soak_left", 160'(q.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
